// File: rtl/accelerator_matrix_pkg.sv
// Shared types and constants for the matrix integration stages.
// The sequencer FSM states and the FIFO status bundle live here.
package accelerator_matrix_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [63:0] ZERO_CONTROL = 64'd0;
    localparam logic [63:0] ONE_CONTROL  = 64'd1;
    localparam logic [63:0] ZERO_DATA    = 64'd0;
    localparam logic [63:0] ONE_DATA     = 64'd1;

    typedef struct packed {
        logic full;
        logic empty;
    } fifo_flags_t;

endpackage

// File: rtl/accelerator_fifo.sv
// Synchronous FIFO with show-ahead read data.
// A push into a full FIFO is dropped even when a pop happens in the same cycle.
module accelerator_fifo #(
    parameter int DATA_SIZE  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_SIZE-1:0] pop_data,
    output logic                 full,
    output logic                 empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 do_push, do_pop;

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/accelerator_matrix_integration_sequencer.sv
// Buffers a row-major element stream and re-issues it as (i,j)-tagged beats
// with matrix/vector/scalar enables; one START runs one SIZE_I x SIZE_J matrix.
module accelerator_matrix_integration_sequencer
    import accelerator_matrix_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic [DATA_SIZE-1:0] SIZE_I_IN,
    input  logic [DATA_SIZE-1:0] SIZE_J_IN,
    input  logic                 DATA_IN_VALID,
    output logic                 DATA_IN_READY,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    input  logic                 DATA_OUT_READY,
    output logic                 DATA_OUT_MATRIX_ENABLE,
    output logic                 DATA_OUT_VECTOR_ENABLE,
    output logic                 DATA_OUT_SCALAR_ENABLE,
    output logic [DATA_SIZE-1:0] INDEX_I_OUT,
    output logic [DATA_SIZE-1:0] INDEX_J_OUT,
    output logic [DATA_SIZE-1:0] DATA_OUT
);
    localparam logic [DATA_SIZE-1:0]    D_ZERO = DATA_SIZE'(ZERO_DATA);
    localparam logic [DATA_SIZE-1:0]    D_ONE  = DATA_SIZE'(ONE_DATA);
    localparam logic [CONTROL_SIZE-1:0] C_ZERO = CONTROL_SIZE'(ZERO_CONTROL);
    localparam logic [CONTROL_SIZE-1:0] C_ONE  = CONTROL_SIZE'(ONE_CONTROL);

    state_t                  state, next_state;
    logic [DATA_SIZE-1:0]    size_i, size_j, idx_i, idx_j, fifo_data;
    logic [CONTROL_SIZE-1:0] total, in_count;
    fifo_flags_t             fifo_st;
    logic                    push, pop, last_col, last_beat, sizes_zero;

    accelerator_fifo #(
        .DATA_SIZE (DATA_SIZE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (push),
        .push_data(DATA_IN),
        .pop      (pop),
        .pop_data (fifo_data),
        .full     (fifo_st.full),
        .empty    (fifo_st.empty)
    );

    // Input ready depends only on registered state, never on DATA_OUT_READY.
    assign DATA_IN_READY = (state == RUN) && (in_count < total) && !fifo_st.full;
    assign push          = DATA_IN_VALID && DATA_IN_READY;
    assign pop           = (state == RUN) && !fifo_st.empty && DATA_OUT_READY;
    assign last_col      = (idx_j == size_j - D_ONE);
    assign last_beat     = pop && last_col && (idx_i == size_i - D_ONE);
    assign sizes_zero    = (SIZE_I_IN == D_ZERO) || (SIZE_J_IN == D_ZERO);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (START) next_state = sizes_zero ? FINISH : RUN;
            RUN:     if (last_beat) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            size_i                 <= D_ZERO;
            size_j                 <= D_ZERO;
            idx_i                  <= D_ZERO;
            idx_j                  <= D_ZERO;
            total                  <= C_ZERO;
            in_count               <= C_ZERO;
            READY                  <= 1'b0;
            DATA_OUT_MATRIX_ENABLE <= 1'b0;
            DATA_OUT_VECTOR_ENABLE <= 1'b0;
            DATA_OUT_SCALAR_ENABLE <= 1'b0;
            INDEX_I_OUT            <= D_ZERO;
            INDEX_J_OUT            <= D_ZERO;
            DATA_OUT               <= D_ZERO;
        end else begin
            READY                  <= (state == FINISH);
            DATA_OUT_MATRIX_ENABLE <= pop && (idx_i == D_ZERO) && (idx_j == D_ZERO);
            DATA_OUT_VECTOR_ENABLE <= pop && (idx_j == D_ZERO);
            DATA_OUT_SCALAR_ENABLE <= pop;
            if (state == IDLE && START) begin
                size_i   <= SIZE_I_IN;
                size_j   <= SIZE_J_IN;
                total    <= CONTROL_SIZE'(SIZE_I_IN) * CONTROL_SIZE'(SIZE_J_IN);
                in_count <= C_ZERO;
                idx_i    <= D_ZERO;
                idx_j    <= D_ZERO;
            end
            if (push) in_count <= in_count + C_ONE;
            if (pop) begin
                DATA_OUT    <= fifo_data;
                INDEX_I_OUT <= idx_i;
                INDEX_J_OUT <= idx_j;
                if (last_col) begin
                    idx_j <= D_ZERO;
                    idx_i <= idx_i + D_ONE;
                end else begin
                    idx_j <= idx_j + D_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_accelerator_matrix_integration_sequencer.sv
// Randomized bench for the matrix sequencer; expected beats come from
// row-major arithmetic (k / SIZE_J, k % SIZE_J) over the accepted element order.
module tb_accelerator_matrix_integration_sequencer;

    typedef struct packed {
        logic        m;
        logic        v;
        logic [63:0] i;
        logic [63:0] j;
        logic [63:0] d;
    } beat_t;

    logic        CLK, RST, START, READY;
    logic [63:0] SIZE_I_IN, SIZE_J_IN, DATA_IN;
    logic        DATA_IN_VALID, DATA_IN_READY, DATA_OUT_READY;
    logic        DATA_OUT_MATRIX_ENABLE, DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE;
    logic [63:0] INDEX_I_OUT, INDEX_J_OUT, DATA_OUT;

    int checks = 0;
    int failures = 0;

    logic [63:0] src[$];
    beat_t       obs[$];
    int          obs_iter[$];
    int          acc_iters[$];
    int          ready_iters[$];
    int          max_occ, stray_en;
    bit          in_rdy_seen, full_block_seen, rst_zero, timed_out;

    accelerator_matrix_integration_sequencer dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .START                 (START),
        .READY                 (READY),
        .SIZE_I_IN             (SIZE_I_IN),
        .SIZE_J_IN             (SIZE_J_IN),
        .DATA_IN_VALID         (DATA_IN_VALID),
        .DATA_IN_READY         (DATA_IN_READY),
        .DATA_IN               (DATA_IN),
        .DATA_OUT_READY        (DATA_OUT_READY),
        .DATA_OUT_MATRIX_ENABLE(DATA_OUT_MATRIX_ENABLE),
        .DATA_OUT_VECTOR_ENABLE(DATA_OUT_VECTOR_ENABLE),
        .DATA_OUT_SCALAR_ENABLE(DATA_OUT_SCALAR_ENABLE),
        .INDEX_I_OUT           (INDEX_I_OUT),
        .INDEX_J_OUT           (INDEX_J_OUT),
        .DATA_OUT              (DATA_OUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Drives one transfer cycle by cycle and records what the DUT shows; no judging here.
    task automatic run_xfer(input int si, input int sj, input int vmode, input int rdy_rand,
                            input int stall_beat, input int stall_len, input int rst_beat,
                            input int restart_iter, input int budget);
        int it, src_idx, stall_left, done_at, occ;
        bit stall_used;
        beat_t b;
        obs.delete(); obs_iter.delete(); acc_iters.delete(); ready_iters.delete();
        max_occ = 0; stray_en = 0; in_rdy_seen = 0; full_block_seen = 0;
        rst_zero = 0; timed_out = 0;
        it = 0; src_idx = 0; stall_left = 0; done_at = -1; stall_used = 0;
        START = 1'b1; SIZE_I_IN = 64'(si); SIZE_J_IN = 64'(sj);
        DATA_OUT_READY = 1'b1; DATA_IN_VALID = 1'b0; DATA_IN = '0;
        forever begin
            @(posedge CLK); #1; it++;
            START     = (it == restart_iter);
            SIZE_I_IN = START ? 64'd3 : 64'(si);
            SIZE_J_IN = START ? 64'd3 : 64'(sj);
            if (DATA_OUT_SCALAR_ENABLE) begin
                b.m = DATA_OUT_MATRIX_ENABLE; b.v = DATA_OUT_VECTOR_ENABLE;
                b.i = INDEX_I_OUT; b.j = INDEX_J_OUT; b.d = DATA_OUT;
                obs.push_back(b);
                obs_iter.push_back(it);
            end else if (DATA_OUT_MATRIX_ENABLE || DATA_OUT_VECTOR_ENABLE) begin
                stray_en++;
            end
            if (READY) begin
                ready_iters.push_back(it);
                if (done_at < 0) done_at = it + 2;
            end
            if (DATA_IN_READY) in_rdy_seen = 1;
            occ = acc_iters.size() - obs.size();
            if (occ > max_occ) max_occ = occ;
            if (occ == 4 && !DATA_IN_READY) full_block_seen = 1;
            if (RST) begin
                rst_zero = ({READY, DATA_IN_READY, DATA_OUT_MATRIX_ENABLE, DATA_OUT_VECTOR_ENABLE,
                             DATA_OUT_SCALAR_ENABLE, INDEX_I_OUT, INDEX_J_OUT, DATA_OUT} == '0);
                RST = 1'b0;
                done_at = it + 4;
            end else if (rst_beat >= 0 && obs.size() == rst_beat && done_at < 0) begin
                RST = 1'b1;
            end
            if (!stall_used && stall_beat >= 0 && obs.size() == stall_beat) begin
                stall_left = stall_len;
                stall_used = 1;
            end
            if (stall_left > 0) begin
                DATA_OUT_READY = 1'b0;
                stall_left--;
            end else begin
                DATA_OUT_READY = (rdy_rand != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            DATA_IN_VALID = (src_idx < src.size()) &&
                            (vmode == 0 || (vmode == 1 && it % 2 == 0) ||
                             (vmode == 2 && $urandom_range(0, 2) != 0));
            DATA_IN = DATA_IN_VALID ? src[src_idx] : '0;
            if (DATA_IN_VALID && DATA_IN_READY && !RST) begin
                acc_iters.push_back(it);
                src_idx++;
            end
            if (done_at >= 0 && it >= done_at) break;
            if (it >= budget) begin
                timed_out = 1;
                break;
            end
        end
        START = 1'b0; DATA_IN_VALID = 1'b0; DATA_OUT_READY = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; DATA_IN_VALID = 1'b0; DATA_OUT_READY = 1'b1;
        SIZE_I_IN = '0; SIZE_J_IN = '0; DATA_IN = '0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({READY, DATA_IN_READY} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ctrl got ready/in_ready=%b want 00", {READY, DATA_IN_READY});
        end
        checks++;
        if ({DATA_OUT_MATRIX_ENABLE, DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE} !== 3'b000) begin
            failures++;
            $display("FAIL reset_en got %b want 000",
                     {DATA_OUT_MATRIX_ENABLE, DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE});
        end
        checks++;
        if ({INDEX_I_OUT, INDEX_J_OUT, DATA_OUT} !== '0) begin
            failures++;
            $display("FAIL reset_data got i=%h j=%h d=%h want 0", INDEX_I_OUT, INDEX_J_OUT, DATA_OUT);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (DATA_IN_READY !== 1'b0) begin
            failures++;
            $display("FAIL idle_in_ready got %b want 0", DATA_IN_READY);
        end
    endtask

    task automatic test_basic_2x3();
        beat_t e;
        src.delete();
        for (int k = 0; k < 6; k++) src.push_back(64'(k + 1));
        run_xfer(2, 3, 0, 0, -1, 0, -1, -1, 100);
        checks++;
        if (timed_out || obs.size() != 6) begin
            failures++;
            $display("FAIL basic_count got %0d beats (timeout=%0d) want 6", obs.size(), timed_out);
        end
        for (int k = 0; k < obs.size() && k < 6; k++) begin
            e.m = (k == 0); e.v = (k % 3 == 0); e.i = 64'(k / 3); e.j = 64'(k % 3); e.d = src[k];
            checks++;
            if (obs[k] !== e) begin
                failures++;
                $display("FAIL basic_beat%0d got %h want %h", k, obs[k], e);
            end
            checks++;
            if (obs_iter[k] != acc_iters[k] + 2) begin
                failures++;
                $display("FAIL basic_latency%0d got %0d want %0d", k, obs_iter[k], acc_iters[k] + 2);
            end
        end
        checks++;
        if (ready_iters.size() != 1 || obs.size() == 0 || ready_iters[0] != obs_iter[obs.size()-1] + 1) begin
            failures++;
            $display("FAIL basic_ready got %0d pulses want 1 one cycle after last beat", ready_iters.size());
        end
        checks++;
        if (stray_en != 0) begin
            failures++;
            $display("FAIL basic_stray_en got %0d want 0", stray_en);
        end
    endtask

    task automatic test_backpressure();
        beat_t e;
        src.delete();
        for (int k = 0; k < 6; k++) src.push_back(rnd64());
        run_xfer(2, 3, 0, 0, 2, 6, -1, -1, 100);
        checks++;
        if (timed_out || obs.size() != 6) begin
            failures++;
            $display("FAIL bp_count got %0d beats want 6", obs.size());
        end
        for (int k = 0; k < obs.size() && k < 6; k++) begin
            e.m = (k == 0); e.v = (k % 3 == 0); e.i = 64'(k / 3); e.j = 64'(k % 3); e.d = src[k];
            checks++;
            if (obs[k] !== e) begin
                failures++;
                $display("FAIL bp_beat%0d got %h want %h", k, obs[k], e);
            end
        end
        checks++;
        if (max_occ != 4 || !full_block_seen) begin
            failures++;
            $display("FAIL bp_fill got occ=%0d blocked=%0d want 4 1", max_occ, full_block_seen);
        end
        checks++;
        if (obs.size() < 3 || obs_iter[2] - obs_iter[1] != 7) begin
            failures++;
            $display("FAIL bp_resume got gap=%0d want 7", obs.size() < 3 ? -1 : obs_iter[2] - obs_iter[1]);
        end
        checks++;
        if (ready_iters.size() != 1) begin
            failures++;
            $display("FAIL bp_ready got %0d pulses want 1", ready_iters.size());
        end
    endtask

    task automatic test_zero_size();
        src.delete();
        for (int k = 0; k < 3; k++) src.push_back(rnd64());
        run_xfer(0, 5, 0, 0, -1, 0, -1, -1, 30);
        checks++;
        if (obs.size() != 0 || in_rdy_seen || acc_iters.size() != 0) begin
            failures++;
            $display("FAIL zero_beats got beats=%0d in_ready=%0d want 0 0", obs.size(), in_rdy_seen);
        end
        checks++;
        if (ready_iters.size() != 1 || ready_iters[0] != 2) begin
            failures++;
            $display("FAIL zero_ready got %0d pulses first=%0d want 1 at 2", ready_iters.size(),
                     ready_iters.size() > 0 ? ready_iters[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        beat_t e;
        src.delete();
        for (int k = 0; k < 9; k++) src.push_back(rnd64());
        run_xfer(3, 3, 0, 0, -1, 0, 4, -1, 60);
        checks++;
        if (obs.size() != 4) begin
            failures++;
            $display("FAIL rst_count got %0d beats want 4", obs.size());
        end
        for (int k = 0; k < obs.size() && k < 4; k++) begin
            e.m = (k == 0); e.v = (k % 3 == 0); e.i = 64'(k / 3); e.j = 64'(k % 3); e.d = src[k];
            checks++;
            if (obs[k] !== e) begin
                failures++;
                $display("FAIL rst_beat%0d got %h want %h", k, obs[k], e);
            end
        end
        checks++;
        if (!rst_zero || ready_iters.size() != 0) begin
            failures++;
            $display("FAIL rst_outputs got zero=%0d ready=%0d want 1 0", rst_zero, ready_iters.size());
        end
        src.delete();
        src.push_back(64'hAA);
        run_xfer(1, 1, 0, 0, -1, 0, -1, -1, 40);
        e.m = 1'b1; e.v = 1'b1; e.i = '0; e.j = '0; e.d = 64'hAA;
        checks++;
        if (obs.size() != 1 || obs[0] !== e) begin
            failures++;
            $display("FAIL one_beat got n=%0d b=%h want 1 %h", obs.size(),
                     obs.size() > 0 ? obs[0] : '0, e);
        end
        checks++;
        if (ready_iters.size() != 1 || obs.size() != 1 || ready_iters[0] != obs_iter[0] + 1) begin
            failures++;
            $display("FAIL one_ready got %0d pulses want 1", ready_iters.size());
        end
    endtask

    task automatic test_restart_ignored();
        beat_t e;
        src.delete();
        for (int k = 0; k < 9; k++) src.push_back(rnd64());
        run_xfer(2, 2, 0, 0, -1, 0, -1, 3, 60);
        checks++;
        if (obs.size() != 4 || acc_iters.size() != 4) begin
            failures++;
            $display("FAIL restart_count got beats=%0d accepted=%0d want 4 4", obs.size(), acc_iters.size());
        end
        for (int k = 0; k < obs.size() && k < 4; k++) begin
            e.m = (k == 0); e.v = (k % 2 == 0); e.i = 64'(k / 2); e.j = 64'(k % 2); e.d = src[k];
            checks++;
            if (obs[k] !== e) begin
                failures++;
                $display("FAIL restart_beat%0d got %h want %h", k, obs[k], e);
            end
        end
        checks++;
        if (ready_iters.size() != 1) begin
            failures++;
            $display("FAIL restart_ready got %0d pulses want 1", ready_iters.size());
        end
    endtask

    task automatic test_toggle_valid();
        beat_t e;
        src.delete();
        for (int k = 0; k < 4; k++) src.push_back(rnd64());
        run_xfer(1, 4, 1, 0, -1, 0, -1, -1, 60);
        checks++;
        if (obs.size() != 4 || stray_en != 0) begin
            failures++;
            $display("FAIL toggle_count got beats=%0d stray=%0d want 4 0", obs.size(), stray_en);
        end
        for (int k = 0; k < obs.size() && k < 4; k++) begin
            e.m = (k == 0); e.v = (k == 0); e.i = '0; e.j = 64'(k); e.d = src[k];
            checks++;
            if (obs[k] !== e || obs_iter[k] != acc_iters[k] + 2) begin
                failures++;
                $display("FAIL toggle_beat%0d got %h at %0d want %h at %0d", k, obs[k], obs_iter[k],
                         e, acc_iters[k] + 2);
            end
        end
    endtask

    task automatic test_random();
        beat_t e;
        int si, sj;
        for (int r = 0; r < 4; r++) begin
            si = $urandom_range(1, 4);
            sj = $urandom_range(1, 5);
            src.delete();
            for (int k = 0; k < si * sj; k++) src.push_back(rnd64());
            run_xfer(si, sj, 2, 1, -1, 0, -1, -1, 400);
            checks++;
            if (timed_out || obs.size() != si * sj) begin
                failures++;
                $display("FAIL rand%0d_count got %0d beats want %0d", r, obs.size(), si * sj);
            end
            for (int k = 0; k < obs.size() && k < si * sj; k++) begin
                e.m = (k == 0); e.v = (k % sj == 0); e.i = 64'(k / sj); e.j = 64'(k % sj); e.d = src[k];
                checks++;
                if (obs[k] !== e) begin
                    failures++;
                    $display("FAIL rand%0d_beat%0d got %h want %h", r, k, obs[k], e);
                end
            end
            checks++;
            if (ready_iters.size() != 1 || obs.size() == 0 || ready_iters[0] != obs_iter[obs.size()-1] + 1
                || max_occ > 4) begin
                failures++;
                $display("FAIL rand%0d_ready got pulses=%0d occ=%0d want 1 <=4", r, ready_iters.size(), max_occ);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_2x3();
        test_backpressure();
        test_zero_size();
        test_reset_mid();
        test_restart_ignored();
        test_toggle_valid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
